deco_rr_scheduler: RTL

- Shares one 4-bit-to-2-digit-BCD decoder instance (enable-gated, 8-bit output, high-Z when disabled) among N_REQ requesters.
- Arbitrates round-robin and latches the granted nibble.
- Drives the decoder's a/enable pins for a settle cycle, then samples its 8-bit output.
- Returns the result with requester ID over a valid/ready response port.
- Sits between the digit-producing blocks and the shared decoder, and is the only driver of the decoder enable.

---
 rtl/deco_sched_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/deco_rr_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/deco_sched_pkg.sv
// Shared types and helpers for the round-robin BCD decoder scheduler.
package deco_sched_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

  localparam int NIBBLE_W = 4;
  localparam int BCD_W    = 8;
  localparam int MAX_REQ  = 8;

  // First set bit of valid at or above ptr, wrapping modulo n (n <= MAX_REQ, ptr < n).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    logic [3:0] n4;
    pick  = '0;
    found = 1'b0;
    n4    = 4'(n);
    for (int i = 0; i < n; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n4) idx = idx - n4;
      if (!found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index, gated by en.
module rr_arbiter
  import deco_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         pick;

  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
      if (gi < N_REQ) begin : g_used
        assign valid_ext[gi] = valid[gi];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign pick = rr_pick(valid_ext, 3'(ptr), N_REQ);
  assign any  = |valid;
  assign idx  = pick[ID_W-1:0];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = en && any && (pick == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/deco_rr_scheduler.sv
// Round-robin scheduler sharing one enable-gated BCD decoder among N_REQ
// requesters: grant, drive+settle, sample, then valid/ready response.
module deco_rr_scheduler
  import deco_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [NIBBLE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [NIBBLE_W-1:0]       deco_a,
  output logic                      deco_en,
  input  logic [BCD_W-1:0]          deco_b,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [BCD_W-1:0]          rsp_data,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_cnt
);

  state_t              state_reg, state_next;
  logic [NIBBLE_W-1:0] nibble_reg;
  logic [ID_W-1:0]     gid_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     rr_ptr_next;
  logic [BCD_W-1:0]    rsp_data_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [CNT_W-1:0]    done_cnt_reg;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [ID_W:0]       ptr_inc;
  logic [NIBBLE_W-1:0] req_nib [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_nib
      assign req_nib[gi] = req_data[NIBBLE_W*gi +: NIBBLE_W];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr_reg),
    .en    (state_reg == IDLE),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign ptr_inc     = {1'b0, grant_idx} + (ID_W+1)'(1);
  assign rr_ptr_next = (ptr_inc == (ID_W+1)'(N_REQ)) ? '0 : ptr_inc[ID_W-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = DRIVE;
      DRIVE:   state_next = SAMPLE;
      SAMPLE:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      nibble_reg   <= '0;
      gid_reg      <= '0;
      rr_ptr_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_id_reg   <= '0;
      done_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (grant_any) begin
          nibble_reg <= req_nib[grant_idx];
          gid_reg    <= grant_idx;
          rr_ptr_reg <= rr_ptr_next;
        end
        // deco_b has had a full settle cycle by now
        SAMPLE: begin
          rsp_data_reg <= deco_b;
          rsp_id_reg   <= gid_reg;
        end
        RESP: if (rsp_ready) done_cnt_reg <= done_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

  // Decoder only enabled, and a only nonzero, while the nibble is in flight.
  assign deco_en   = (state_reg == DRIVE) || (state_reg == SAMPLE);
  assign deco_a    = deco_en ? nibble_reg : '0;
  assign req_ready = grant;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);
  assign done_cnt  = done_cnt_reg;

endmodule
